// File: rtl/bullet_ctrl.sv
// Per-tank bullet launcher and flight tracker: 13-bit fixed-point position (3 fractional bits), wall/screen bounce, lifetime and cooldown.
// Optional macro BULLET_BOUNCE_LIMIT_EN retires the bullet once it would exceed MAX_BOUNCES bounces.
module bullet_ctrl #(
  parameter int unsigned BULLET_SPEED = 32,
  parameter int unsigned LIFETIME     = 300,
  parameter int unsigned COOLDOWN     = 15,
  parameter int unsigned BULLET_SIZE  = 2,
  parameter int unsigned MAX_BOUNCES  = 5
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       ShootBullet,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [9:0] TankS,
  input  logic [7:0] sin,
  input  logic [7:0] cos,
  input  logic       isWallLeft,
  input  logic       isWallRight,
  input  logic       isWallTop,
  input  logic       isWallBottom,
  input  logic       hit,
  input  logic [1:0] game_end,
  output logic [9:0] BulletX,
  output logic [9:0] BulletY,
  output logic [9:0] BulletS,
  output logic       BulletActive,
  output logic       ShotFired
);

  localparam int unsigned POS_W  = 13;
  localparam int unsigned LIFE_W = $clog2(LIFETIME + 1);
  localparam int unsigned CD_W   = $clog2(COOLDOWN + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FLIGHT = 2'd1;
  localparam logic [1:0] S_COOL   = 2'd2;

  // Last in-screen positions in 1/8 px: 639 px and 479 px plus the fraction.
  localparam logic [POS_W-1:0] X_LIM = POS_W'(640 * 8 - 1);
  localparam logic [POS_W-1:0] Y_LIM = POS_W'(480 * 8 - 1);

  logic [1:0]       state, state_d;
  logic [POS_W-1:0] pos_x, pos_x_d, pos_y, pos_y_d;
  logic [POS_W-1:0] vel_x, vel_x_d, vel_y, vel_y_d;
  logic [LIFE_W-1:0] life, life_d;
  logic [CD_W-1:0]  cd, cd_d;
  logic             active, active_d;
  logic             shot, shot_d;
  logic             shoot_q;

  // Launch geometry: muzzle offset and velocity from sign-magnitude sin/cos.
  logic             fire;
  logic [13:0]      off;
  logic [20:0]      off_x_p, off_y_p;
  logic [POS_W-1:0] off_x, off_y, spd_x, spd_y, base_x, base_y;
  logic [POS_W-1:0] launch_x, launch_y, launch_vx, launch_vy;

  assign fire     = ShootBullet & ~shoot_q;
  assign off      = {11'(TankS) + 11'd2, 3'b000};
  assign off_x_p  = 21'(off) * 21'(cos[6:0]);
  assign off_y_p  = 21'(off) * 21'(sin[6:0]);
  assign off_x    = POS_W'(off_x_p >> 7);
  assign off_y    = POS_W'(off_y_p >> 7);
  assign spd_x    = POS_W'((BULLET_SPEED * 32'(cos[6:0])) >> 7);
  assign spd_y    = POS_W'((BULLET_SPEED * 32'(sin[6:0])) >> 7);
  assign base_x   = {TankX, 3'b000};
  assign base_y   = {TankY, 3'b000};
  assign launch_x = cos[7] ? base_x - off_x : base_x + off_x;
  assign launch_y = sin[7] ? base_y + off_y : base_y - off_y;
  assign launch_vx = cos[7] ? POS_W'(0) - spd_x : spd_x;
  assign launch_vy = sin[7] ? spd_y : POS_W'(0) - spd_y;

  // Bounce decision uses the pre-flip next position; the move uses the post-flip velocity.
  logic [POS_W-1:0] next_x, next_y, step_x, step_y;
  logic             flip_x, flip_y, flip_any, retire;

  assign next_x   = pos_x + vel_x;
  assign next_y   = pos_y + vel_y;
  assign flip_x   = isWallLeft | isWallRight | (next_x > X_LIM);
  assign flip_y   = isWallTop | isWallBottom | (next_y > Y_LIM);
  assign flip_any = flip_x | flip_y;
  assign step_x   = flip_x ? POS_W'(0) - vel_x : vel_x;
  assign step_y   = flip_y ? POS_W'(0) - vel_y : vel_y;

`ifdef BULLET_BOUNCE_LIMIT_EN
  localparam int unsigned BNC_W = $clog2(MAX_BOUNCES + 1);
  logic [BNC_W-1:0] bounce, bounce_d;

  assign retire = hit | (life == LIFE_W'(1)) | (flip_any & (bounce == BNC_W'(MAX_BOUNCES)));

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) bounce <= '0;
    else          bounce <= bounce_d;
  end

  always_comb begin
    bounce_d = bounce;
    if (state == S_IDLE && fire) begin
      bounce_d = '0;
    end else if (state == S_FLIGHT && game_end == 2'd0 && !retire && flip_any) begin
      bounce_d = bounce + BNC_W'(1);
    end
  end
`else
  logic [31:0] bounce_unused;
  assign bounce_unused = MAX_BOUNCES;
  assign retire = hit | (life == LIFE_W'(1));
`endif

  // State and datapath registers.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= S_IDLE;
      pos_x   <= '0;
      pos_y   <= '0;
      vel_x   <= '0;
      vel_y   <= '0;
      life    <= '0;
      cd      <= '0;
      active  <= 1'b0;
      shot    <= 1'b0;
      shoot_q <= 1'b0;
    end else begin
      state   <= state_d;
      pos_x   <= pos_x_d;
      pos_y   <= pos_y_d;
      vel_x   <= vel_x_d;
      vel_y   <= vel_y_d;
      life    <= life_d;
      cd      <= cd_d;
      active  <= active_d;
      shot    <= shot_d;
      shoot_q <= ShootBullet;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state;
    pos_x_d = pos_x;
    pos_y_d = pos_y;
    vel_x_d = vel_x;
    vel_y_d = vel_y;
    life_d  = life;
    cd_d    = cd;
    shot_d  = 1'b0;
    case (state)
      S_IDLE: begin
        if (fire) begin
          pos_x_d = launch_x;
          pos_y_d = launch_y;
          vel_x_d = launch_vx;
          vel_y_d = launch_vy;
          life_d  = LIFE_W'(LIFETIME);
          shot_d  = 1'b1;
          state_d = S_FLIGHT;
        end
      end
      S_FLIGHT: begin
        if (game_end != 2'd0) begin
          state_d = S_IDLE;
        end else if (retire) begin
          cd_d    = CD_W'(COOLDOWN);
          state_d = S_COOL;
        end else begin
          vel_x_d = step_x;
          vel_y_d = step_y;
          pos_x_d = pos_x + step_x;
          pos_y_d = pos_y + step_y;
          life_d  = life - LIFE_W'(1);
        end
      end
      S_COOL: begin
        if (game_end != 2'd0 || cd <= CD_W'(1)) begin
          cd_d    = '0;
          state_d = S_IDLE;
        end else begin
          cd_d = cd - CD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    active_d = (state_d == S_FLIGHT);
  end

  assign BulletX      = pos_x[12:3];
  assign BulletY      = pos_y[12:3];
  assign BulletS      = 10'(BULLET_SIZE);
  assign BulletActive = active;
  assign ShotFired    = shot;

endmodule
